// File: rtl/approx_wallace_mac.sv
// approx_wallace_mac: three-stage unsigned multiply-accumulate built on a
// ripple-layer partial-product array. Low product columns can switch to
// approximate full-adder cells on a per-transaction basis.
// S1 holds operands, S2 holds the array product, S3 holds the accumulator and
// the presented result. The whole pipeline holds while the consumer stalls,
// but empty stages still fill so bubbles collapse.
module approx_wallace_mac #(
    parameter int WIDTH       = 8,
    parameter int ACC_WIDTH   = 24,
    parameter int APPROX_COLS = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       a_in,
    input  logic [WIDTH-1:0]       b_in,
    input  logic                   approx_en,
    input  logic                   acc_clr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*WIDTH-1:0]     prod_o,
    output logic [ACC_WIDTH-1:0]   acc_o,
    output logic                   ovf_o
);

    localparam int PW = 2 * WIDTH;

    // Stage 1: captured operands and mode bits
    logic                 r_s1_valid;
    logic [WIDTH-1:0]     r_s1_a;
    logic [WIDTH-1:0]     r_s1_b;
    logic                 r_s1_approx;
    logic                 r_s1_clr;

    // Stage 2: array result
    logic                 r_s2_valid;
    logic [PW-1:0]        r_s2_prod;
    logic                 r_s2_clr;

    // Stage 3: presented result and accumulator
    logic                 r_s3_valid;
    logic [PW-1:0]        r_prod;
    logic [ACC_WIDTH-1:0] r_acc;
    logic                 r_ovf;

    logic                 w_stall;
    logic                 w_en1;
    logic                 w_en2;
    logic                 w_en3;
    logic [PW-1:0]        w_array_prod;
    logic [ACC_WIDTH:0]   w_acc_sum;

    // A stage loads when the stage after it is moving or when it is itself empty.
    assign w_stall   = r_s3_valid & ~out_ready;
    assign w_en3     = ~w_stall;
    assign w_en2     = w_en3 | ~r_s2_valid;
    assign w_en1     = w_en2 | ~r_s1_valid;
    assign in_ready  = ~w_stall;

    assign out_valid = r_s3_valid;
    assign prod_o    = r_prod;
    assign acc_o     = r_acc;
    assign ovf_o     = r_ovf;

    // Capture a new transaction (or a bubble) into stage 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_approx <= 1'b0;
            r_s1_clr    <= 1'b0;
        end else if (w_en1) begin
            r_s1_valid  <= in_valid & in_ready;
            r_s1_a      <= a_in;
            r_s1_b      <= b_in;
            r_s1_approx <= approx_en;
            r_s1_clr    <= acc_clr;
        end
    end

    // Ripple-layer array: each layer adds one shifted partial-product row to
    // the running sum through a chain of full-adder cells. Cells in the low
    // APPROX_COLS columns drop the sum bit for the all-ones input when the
    // transaction requests approximate mode.
    always_comb begin : array_eval
        logic [PW-1:0] v_sum;
        logic          v_cy;
        logic          v_a;
        logic          v_b;
        logic          v_maj;
        logic          v_s;
        v_sum = {{WIDTH{1'b0}}, r_s1_a & {WIDTH{r_s1_b[0]}}};
        v_cy  = 1'b0;
        v_a   = 1'b0;
        v_b   = 1'b0;
        v_maj = 1'b0;
        v_s   = 1'b0;
        for (int k = 1; k < WIDTH; k++) begin
            v_cy = 1'b0;
            for (int j = 0; j < WIDTH; j++) begin
                v_a   = v_sum[k + j];
                v_b   = r_s1_a[j] & r_s1_b[k];
                v_maj = (v_a & v_b) | (v_a & v_cy) | (v_b & v_cy);
                if (r_s1_approx && ((k + j) < APPROX_COLS)) begin
                    v_s = (v_a | v_b | v_cy) & ~v_maj;
                end else begin
                    v_s = v_a ^ v_b ^ v_cy;
                end
                v_sum[k + j] = v_s;
                v_cy         = v_maj;
            end
            v_sum[k + WIDTH] = v_cy;
        end
        w_array_prod = v_sum;
    end

    // Register the array product with its accumulate-mode bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_prod  <= '0;
            r_s2_clr   <= 1'b0;
        end else if (w_en2) begin
            r_s2_valid <= r_s1_valid;
            r_s2_prod  <= w_array_prod;
            r_s2_clr   <= r_s1_clr;
        end
    end

    // Extra top bit of the sum is the wrap indication for the sticky flag
    assign w_acc_sum = {1'b0, r_acc} + (ACC_WIDTH + 1)'(r_s2_prod);

    // Present the result and fold it into the accumulator on a valid advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s3_valid <= 1'b0;
            r_prod     <= '0;
            r_acc      <= '0;
            r_ovf      <= 1'b0;
        end else if (w_en3) begin
            r_s3_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_prod <= r_s2_prod;
                if (r_s2_clr) begin
                    r_acc <= ACC_WIDTH'(r_s2_prod);
                    r_ovf <= 1'b0;
                end else begin
                    r_acc <= w_acc_sum[ACC_WIDTH-1:0];
                    r_ovf <= r_ovf | w_acc_sum[ACC_WIDTH];
                end
            end
        end
    end

endmodule

// File: tb/tb_approx_wallace_mac.sv
// Bench for approx_wallace_mac: two instances share one stimulus stream, one
// with the default 24-bit accumulator and one with a 17-bit accumulator so
// wrap behaviour shows up quickly. A scoreboard of accepted transactions and
// an arithmetic model of the approximate array check every presented result.
module tb_approx_wallace_mac;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  a_in;
    logic [7:0]  b_in;
    logic        approx_en;
    logic        acc_clr;
    logic        out_ready;

    logic        in_ready0;
    logic        out_valid0;
    logic [15:0] prod0;
    logic [23:0] acc0;
    logic        ovf0;

    logic        in_ready1;
    logic        out_valid1;
    logic [15:0] prod1;
    logic [16:0] acc1;
    logic        ovf1;

    int n_vec;
    int n_bad;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       ap;
        logic       clr;
    } txn_t;

    txn_t   q[$];
    longint m_acc0;
    longint m_acc1;
    bit     m_ovf0;
    bit     m_ovf1;

    approx_wallace_mac #(.WIDTH(8), .ACC_WIDTH(24), .APPROX_COLS(8)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .a_in(a_in), .b_in(b_in), .approx_en(approx_en), .acc_clr(acc_clr),
        .out_valid(out_valid0), .out_ready(out_ready),
        .prod_o(prod0), .acc_o(acc0), .ovf_o(ovf0)
    );

    approx_wallace_mac #(.WIDTH(8), .ACC_WIDTH(17), .APPROX_COLS(8)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .a_in(a_in), .b_in(b_in), .approx_en(approx_en), .acc_clr(acc_clr),
        .out_valid(out_valid1), .out_ready(out_ready),
        .prod_o(prod1), .acc_o(acc1), .ovf_o(ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Product model: add rows one at a time, counting ones per column. An
    // approximate column that sees three ones keeps the carry but loses the sum.
    function automatic logic [15:0] model_mult(input logic [7:0] a, input logic [7:0] b,
                                               input logic ap);
        int sum;
        int carry;
        int t;
        int bitv;
        int c;
        if (!ap) return 16'(int'(a) * int'(b));
        sum = b[0] ? int'(a) : 0;
        for (int k = 1; k < 8; k++) begin
            if (((int'(b) >> k) & 1) == 1) begin
                carry = 0;
                for (int j = 0; j < 8; j++) begin
                    c     = k + j;
                    t     = ((sum >> c) & 1) + ((int'(a) >> j) & 1) + carry;
                    carry = t / 2;
                    bitv  = t % 2;
                    if (c < 8 && t == 3) bitv = 0;
                    sum   = (sum & ~(1 << c)) | (bitv << c);
                end
                sum = (sum & ~(1 << (k + 8))) | (carry << (k + 8));
            end
        end
        return 16'(sum);
    endfunction

    // Scoreboard: sample every falling edge, check each newly presented result
    // against the model, check held results during stalls, then log acceptances.
    logic        prev_stall;
    logic [15:0] prev_prod0;
    logic [23:0] prev_acc0;
    logic        prev_ovf0;
    logic [16:0] prev_acc1;
    logic        prev_ovf1;

    always @(negedge clk) begin
        txn_t        t;
        logic [15:0] p;
        longint      s;
        if (rst) begin
            check("rst_valid", 32'(out_valid0), 32'd0);
            check("rst_ready", 32'(in_ready0), 32'd1);
            check("rst_acc", 32'(acc0), 32'd0);
            check("rst_ovf1", 32'(ovf1), 32'd0);
            q.delete();
            m_acc0 = 0; m_acc1 = 0; m_ovf0 = 0; m_ovf1 = 0;
            prev_stall = 1'b0;
        end else begin
            check("in_ready0", 32'(in_ready0), 32'(!(out_valid0 && !out_ready)));
            check("in_ready1", 32'(in_ready1), 32'(!(out_valid1 && !out_ready)));
            if (prev_stall) begin
                check("held_valid", 32'(out_valid0), 32'd1);
                check("held_prod", 32'(prod0), 32'(prev_prod0));
                check("held_acc0", 32'(acc0), 32'(prev_acc0));
                check("held_ovf0", 32'(ovf0), 32'(prev_ovf0));
                check("held_acc1", 32'(acc1), 32'(prev_acc1));
                check("held_ovf1", 32'(ovf1), 32'(prev_ovf1));
            end else if (out_valid0) begin
                if (q.size() == 0) begin
                    check("spurious_out", 32'(out_valid0), 32'd0);
                end else begin
                    t = q.pop_front();
                    p = model_mult(t.a, t.b, t.ap);
                    if (t.clr) begin
                        m_acc0 = p; m_ovf0 = 0;
                        m_acc1 = p; m_ovf1 = 0;
                    end else begin
                        s = m_acc0 + p;
                        if (s >= 64'd16777216) begin s -= 64'd16777216; m_ovf0 = 1; end
                        m_acc0 = s;
                        s = m_acc1 + p;
                        if (s >= 64'd131072) begin s -= 64'd131072; m_ovf1 = 1; end
                        m_acc1 = s;
                    end
                    check("valid1", 32'(out_valid1), 32'd1);
                    check("prod0", 32'(prod0), 32'(p));
                    check("prod1", 32'(prod1), 32'(p));
                    check("acc0", 32'(acc0), 32'(m_acc0));
                    check("ovf0", 32'(ovf0), 32'(m_ovf0));
                    check("acc1", 32'(acc1), 32'(m_acc1));
                    check("ovf1", 32'(ovf1), 32'(m_ovf1));
                end
            end
            prev_stall = out_valid0 & ~out_ready;
            prev_prod0 = prod0;
            prev_acc0  = acc0;
            prev_ovf0  = ovf0;
            prev_acc1  = acc1;
            prev_ovf1  = ovf1;
            if (in_valid && in_ready0) begin
                t.a = a_in; t.b = b_in; t.ap = approx_en; t.clr = acc_clr;
                q.push_back(t);
            end
        end
    end

    // Present one transaction and hold it until an edge accepts it
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic ap, input logic clr);
        logic got;
        int   n;
        a_in = a; b_in = b; approx_en = ap; acc_clr = clr; in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            got = in_ready0;
            @(posedge clk);
            #2;
            n++;
        end while (!got && n < 50);
        if (!got) check("send_timeout", 32'(got), 32'd1);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    // Wait for the next presented result; n counts falling edges waited
    task automatic wait_result(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid0 && n < 20);
        if (!out_valid0) check("result_timeout", 32'(out_valid0), 32'd1);
    endtask

    task automatic consume();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [7:0] pick();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 8'd0;
        if (r == 1) return 8'd255;
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        int n;
        rst = 1'b1; in_valid = 1'b0; a_in = '0; b_in = '0;
        approx_en = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
        n_vec = 0; n_bad = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid0), 32'd0);
        check("reset_in_ready", 32'(in_ready0), 32'd1);
        check("reset_prod", 32'(prod0), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Exact 255*255 with clear, including latency
        send(8'd255, 8'd255, 1'b0, 1'b1); idle();
        wait_result(n);
        check("latency", 32'(n), 32'd3);
        check("lit_prod_255sq", 32'(prod0), 32'd65025);
        check("lit_acc_255sq", 32'(acc0), 32'd65025);
        check("lit_ovf_255sq", 32'(ovf0), 32'd0);
        consume();

        // Approximate 7*3 then exact 7*3 accumulated
        send(8'd7, 8'd3, 1'b1, 1'b1); idle();
        wait_result(n);
        check("lit_prod_7x3_apx", 32'(prod0), 32'd17);
        check("lit_acc_7x3_apx", 32'(acc0), 32'd17);
        consume();
        send(8'd7, 8'd3, 1'b0, 1'b0); idle();
        wait_result(n);
        check("lit_prod_7x3_ex", 32'(prod0), 32'd21);
        check("lit_acc_38", 32'(acc0), 32'd38);
        consume();

        // Approximate cases that never hit an all-ones cell
        send(8'd0, 8'd200, 1'b1, 1'b1); idle();
        wait_result(n);
        check("lit_prod_0x200", 32'(prod0), 32'd0);
        consume();
        send(8'd3, 8'd3, 1'b1, 1'b0); idle();
        wait_result(n);
        check("lit_prod_3x3_apx", 32'(prod0), 32'd9);
        check("lit_acc_9", 32'(acc0), 32'd9);
        consume();

        // 17-bit accumulator wrap and sticky flag, then clear
        send(8'd255, 8'd255, 1'b0, 1'b1); idle();
        wait_result(n);
        check("lit_acc17_load", 32'(acc1), 32'd65025);
        check("lit_ovf17_load", 32'(ovf1), 32'd0);
        consume();
        send(8'd255, 8'd255, 1'b0, 1'b0); idle();
        wait_result(n);
        check("lit_acc17_add1", 32'(acc1), 32'd130050);
        check("lit_ovf17_add1", 32'(ovf1), 32'd0);
        consume();
        send(8'd255, 8'd255, 1'b0, 1'b0); idle();
        wait_result(n);
        check("lit_acc17_add2", 32'(acc1), 32'd64003);
        check("lit_ovf17_add2", 32'(ovf1), 32'd1);
        consume();
        send(8'd255, 8'd255, 1'b0, 1'b0); idle();
        wait_result(n);
        check("lit_acc17_add3", 32'(acc1), 32'd129028);
        check("lit_ovf17_add3", 32'(ovf1), 32'd1);
        consume();
        send(8'd1, 8'd1, 1'b0, 1'b1); idle();
        wait_result(n);
        check("lit_acc17_clr", 32'(acc1), 32'd1);
        check("lit_ovf17_clr", 32'(ovf1), 32'd0);
        consume();

        // Backpressure: five back-to-back, then a 4-cycle consumer stall
        for (int i = 0; i < 5; i++) send(pick(), pick(), 1'($urandom_range(0, 1)), 1'b0);
        a_in = pick(); b_in = pick(); approx_en = 1'b1; acc_clr = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready0), 32'd0);
            @(posedge clk);
            #2;
        end
        out_ready = 1'b1;
        send(a_in, b_in, 1'b1, 1'b0); idle();
        repeat (8) @(posedge clk);
        #2;

        // Randomised mixed traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            a_in      = pick();
            b_in      = pick();
            approx_en = 1'($urandom_range(0, 1));
            acc_clr   = ($urandom_range(0, 9) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #2;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #2;
        check("drain_empty", 32'(q.size()), 32'd0);

        // Reset with transactions in flight
        send(8'd9, 8'd9, 1'b0, 1'b1);
        send(8'd5, 8'd6, 1'b1, 1'b0);
        send(8'd4, 8'd4, 1'b0, 1'b0);
        rst = 1'b1; in_valid = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid0), 32'd0);
        check("async_rst_prod", 32'(prod0), 32'd0);
        check("async_rst_acc", 32'(acc0), 32'd0);
        check("async_rst_ovf", 32'(ovf0), 32'd0);
        check("async_rst_ready", 32'(in_ready0), 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        send(8'd2, 8'd3, 1'b0, 1'b0); idle();
        wait_result(n);
        check("lit_post_rst_acc0", 32'(acc0), 32'd6);
        check("lit_post_rst_acc1", 32'(acc1), 32'd6);
        consume();
        repeat (4) @(posedge clk);
        #2;
        check("final_empty", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
